mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter for the processor's single-port 16-bit data/instruction memory. It shares the memory between the CPU controller (fetch, LOAD and STOR states) and a device port such as a video scan-out or DMA reader. It sequences each access as a registered grant cycle followed by read-data return, and it guarantees the device port a bounded wait. The CPU controller holds its current state until `cpu_gnt` pulses.

## Interface
Parameters:
- `ADDR_W`, default 16: address width.
- `DATA_W`, default 16: data width.
- `CPU_PRIORITY`, default 1: tie-break mode. 1 means the CPU wins ties, subject to the starvation guard. 0 means strict round-robin.
- `MAX_WAIT`, default 4: device wait-count threshold, from 1 to 15. At this count the device wins a tie when `CPU_PRIORITY`=1.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `cpu_req` input 1: CPU access request. Held until `cpu_gnt`.
- `cpu_we` input 1: 1 = write, 0 = read. Stable while `cpu_req`=1.
- `cpu_addr` input `ADDR_W`: CPU address.
- `cpu_wdata` input `DATA_W`: CPU write data.
- `cpu_gnt` output 1: one-cycle pulse marking the CPU's memory access cycle.
- `cpu_rvalid` output 1: one-cycle pulse, CPU read data valid.
- `cpu_rdata` output `DATA_W`: `mem_rdata` passed through. Meaningful only while `cpu_rvalid`=1.
- `dev_req`, `dev_we`, `dev_addr`, `dev_wdata`: device-side equivalents of the CPU request inputs, same widths and rules.
- `dev_gnt`, `dev_rvalid`, `dev_rdata`: device-side equivalents of the CPU grant and read-return outputs.
- `mem_addr` output `ADDR_W`: registered memory address.
- `mem_wdata` output `DATA_W`: registered memory write data.
- `mem_we` output 1: registered write enable.
- `mem_rdata` input `DATA_W`: synchronous memory read data, valid the cycle after the address is presented.

## Operation
States:
- IDLE: arbitrate.
- GRANT: the memory access cycle.

IDLE:
- No request: stay in IDLE.
- One requester: grant it.
- Both requesting, `CPU_PRIORITY`=1: the CPU wins unless `wait_cnt`==`MAX_WAIT`, in which case the device wins.
- Both requesting, `CPU_PRIORITY`=0: the port that did not win the last grant wins. The last-winner flag resets to DEV, so the CPU wins the first tie.
- On a win: latch the winner's addr, wdata and we into `mem_addr`, `mem_wdata` and `mem_we`. Record the owner and go to GRANT.

GRANT:
- The owner's gnt = 1. `mem_we` equals the latched we.
- Requests are not sampled in this cycle. The owner's req may still be high; it is treated as a new request only from the next IDLE cycle.
- Next state is always IDLE.
- For a read, set an rvalid pipeline bit for the owner.
- `mem_we` returns to 0 on leaving GRANT. `mem_addr` and `mem_wdata` hold their last values.

Read return:
- The owner's rvalid = 1 in the cycle after GRANT. Its rdata = `mem_rdata` in that cycle.
- A write produces no rvalid.

Starvation guard:
- `wait_cnt` is 4 bits. It increments in every cycle where `dev_req`=1 and `dev_gnt`=0, and saturates at `MAX_WAIT`.
- It clears to 0 in the `dev_gnt` cycle.
- It is maintained in both modes but used only when `CPU_PRIORITY`=1.

Mode invariants:
- At most one gnt per cycle. gnt and rvalid for the same port are never high together.
- Peak throughput is one access every 2 cycles.
- The device waits at most 2·`MAX_WAIT`+1 cycles from request to grant.

Reset:
- Values on reset: state = IDLE, all gnt = 0, all rvalid = 0 (including any in-flight rvalid pipeline bit), `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `wait_cnt` = 0, last-winner = DEV.
- Reset asserted during GRANT aborts the access. The write enable is deasserted from the next cycle, and no rvalid is ever produced for that access.

## Timing
- Request sampled in IDLE cycle N, then gnt and the memory access in N+1, then rvalid and rdata in N+2.
- Minimum request-to-gnt latency is 1 cycle.
- Read latency from gnt is 1 cycle.
- A read's rvalid in N+2 may coincide with another port's gnt in N+3 only. It never coincides in N+2, because N+2 is always IDLE.
- All outputs are registered except rdata, which is a combinational pass-through of `mem_rdata`.

## Test plan
1. CPU read: `cpu_req`=1, `cpu_addr`=0x0010 in cycle 0, memory returns 0xBEEF.
   - Required: `cpu_gnt`=1 in cycle 1 with `mem_addr`=0x0010 and `mem_we`=0.
   - Required: `cpu_rvalid`=1 with `cpu_rdata`=0xBEEF in cycle 2.
   - Required: all device outputs stay 0.
2. CPU write: `cpu_we`=1, `cpu_addr`=0x00FF, `cpu_wdata`=0x1234.
   - Required: `mem_we`=1 only in the gnt cycle, with `mem_addr`=0x00FF and `mem_wdata`=0x1234.
   - Required: no `cpu_rvalid` is ever produced.
3. `CPU_PRIORITY`=1, `MAX_WAIT`=4, both req held high from cycle 0.
   - Required: `cpu_gnt` in cycles 1 and 3, `dev_gnt` in cycle 5, `cpu_gnt` in cycle 7.
   - Required: `wait_cnt`=0 after cycle 5.
4. `CPU_PRIORITY`=0, both req held high from cycle 0.
   - Required: grants alternate CPU@1, DEV@3, CPU@5, DEV@7.
5. Reset abort: issue a device read and assert `reset` during its `dev_gnt` cycle.
   - Required: from the next cycle, all outputs are 0 and `dev_rvalid` never pulses.
   - Required: with `cpu_req` then raised, the CPU is granted 1 cycle later.
6. Interleaved traffic: device read at 0x8000 (data 0x00AA) in cycle 0, CPU read at 0x0002 (data 0x5555) arriving in cycle 1.
   - Required: `dev_rvalid` with 0x00AA in cycle 2, `cpu_gnt` in cycle 3, `cpu_rvalid` with 0x5555 in cycle 4.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one synchronous single-port memory between the CPU controller
// and a device port. Each access is a registered grant cycle followed by read-data return.
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int CPU_PRIORITY = 1,
  parameter int MAX_WAIT     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dev_req,
  input  logic              dev_we,
  input  logic [ADDR_W-1:0] dev_addr,
  input  logic [DATA_W-1:0] dev_wdata,
  output logic              dev_gnt,
  output logic              dev_rvalid,
  output logic [DATA_W-1:0] dev_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  state_t     state, state_nxt;
  logic [3:0] wait_cnt;
  logic       last_dev;
  logic       tie_dev, win_cpu, win_dev;

  assign cpu_rdata = mem_rdata;
  assign dev_rdata = mem_rdata;

  always_comb begin
    state_nxt = state;
    tie_dev   = 1'b0;
    win_cpu   = 1'b0;
    win_dev   = 1'b0;
    // Priority mode: the device wins a tie only once its wait has hit the threshold.
    if (CPU_PRIORITY != 0) tie_dev = (wait_cnt == WAIT_MAX);
    else                   tie_dev = !last_dev;
    case (state)
      IDLE: begin
        win_dev = dev_req && (!cpu_req || tie_dev);
        win_cpu = cpu_req && !win_dev;
        if (win_cpu || win_dev) state_nxt = GRANT;
      end
      GRANT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cpu_gnt    <= 1'b0;
      dev_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      dev_rvalid <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      wait_cnt   <= '0;
      last_dev   <= 1'b1;
    end else begin
      state      <= state_nxt;
      cpu_gnt    <= win_cpu;
      dev_gnt    <= win_dev;
      // gnt is high exactly in the owner's GRANT cycle, so it doubles as the read pipe stage
      cpu_rvalid <= cpu_gnt && !mem_we;
      dev_rvalid <= dev_gnt && !mem_we;
      mem_we     <= (win_cpu && cpu_we) || (win_dev && dev_we);
      if (win_cpu) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end else if (win_dev) begin
        mem_addr  <= dev_addr;
        mem_wdata <= dev_wdata;
      end
      if (win_cpu || win_dev) last_dev <= win_dev;
      if (dev_gnt)                             wait_cnt <= '0;
      else if (dev_req && wait_cnt < WAIT_MAX) wait_cnt <= wait_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random and directed traffic against both arbitration modes, checked cycle by cycle
// against a timeline model that schedules grants, read returns and memory contents.
module tb_mem_port_arbiter;
  localparam int AW = 16, DW = 16, MW = 4, NC = 4000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // index 0: round-robin (CPU_PRIORITY=0), index 1: CPU priority
  logic          cpu_req[2], cpu_we[2], dev_req[2], dev_we[2];
  logic [AW-1:0] cpu_addr[2], dev_addr[2], mem_addr[2];
  logic [DW-1:0] cpu_wdata[2], dev_wdata[2], mem_wdata[2], cpu_rdata[2], dev_rdata[2];
  logic          cpu_gnt[2], dev_gnt[2], cpu_rvalid[2], dev_rvalid[2], mem_we[2];

  function automatic logic [DW-1:0] init_val(logic [7:0] a);
    return {a, ~a} ^ 16'h5a3c;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [DW-1:0] ram [256];
    bit   [255:0]  wrote;
    logic [DW-1:0] rd;
    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CPU_PRIORITY(g), .MAX_WAIT(MW)) u_dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]), .cpu_wdata(cpu_wdata[g]),
      .cpu_gnt(cpu_gnt[g]), .cpu_rvalid(cpu_rvalid[g]), .cpu_rdata(cpu_rdata[g]),
      .dev_req(dev_req[g]), .dev_we(dev_we[g]), .dev_addr(dev_addr[g]), .dev_wdata(dev_wdata[g]),
      .dev_gnt(dev_gnt[g]), .dev_rvalid(dev_rvalid[g]), .dev_rdata(dev_rdata[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_we(mem_we[g]), .mem_rdata(rd)
    );
    always @(posedge clk) begin
      if (mem_we[g]) begin
        ram[mem_addr[g][7:0]]   <= mem_wdata[g];
        wrote[mem_addr[g][7:0]] <= 1'b1;
      end
      rd <= wrote[mem_addr[g][7:0]] ? ram[mem_addr[g][7:0]] : init_val(mem_addr[g][7:0]);
    end
  end

  // expected outputs per absolute cycle
  typedef struct packed {
    bit cg, dg, cv, dv, we;
    bit [AW-1:0] ma;
    bit [DW-1:0] mw, rd;
  } exp_t;

  exp_t          ex [2][NC+4];
  logic [DW-1:0] rmem [2][256];
  bit            rwrote [2][256];
  int            wcnt[2];
  bit            last_dev[2];
  int            cyc = 0;
  int            total = 0, bad = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic setp(int m, bit p, bit r, bit w, logic [AW-1:0] a, logic [DW-1:0] d);
    if (p) begin dev_req[m] = r; dev_we[m] = w; dev_addr[m] = a; dev_wdata[m] = d; end
    else   begin cpu_req[m] = r; cpu_we[m] = w; cpu_addr[m] = a; cpu_wdata[m] = d; end
  endtask

  task automatic drive(bit p, bit r, bit w, logic [AW-1:0] a, logic [DW-1:0] d);
    for (int m = 0; m < 2; m++) setp(m, p, r, w, a, d);
  endtask

  // Model the current cycle's inputs, advance one clock, then compare the new cycle.
  task automatic tick();
    exp_t cur;
    bit dwin, w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int m = 0; m < 2; m++) begin
      cur = ex[m][cyc];
      if (reset) begin
        ex[m][cyc+1] = '0;
        wcnt[m] = 0;
        last_dev[m] = 1'b1;
      end else begin
        ex[m][cyc+1].ma = cur.ma;
        ex[m][cyc+1].mw = cur.mw;
        if (!(cur.cg || cur.dg) && (cpu_req[m] || dev_req[m])) begin
          if (cpu_req[m] && dev_req[m]) dwin = (m == 1) ? (wcnt[m] == MW) : !last_dev[m];
          else                          dwin = dev_req[m];
          a = dwin ? dev_addr[m]  : cpu_addr[m];
          d = dwin ? dev_wdata[m] : cpu_wdata[m];
          w = dwin ? dev_we[m]    : cpu_we[m];
          ex[m][cyc+1].cg = !dwin;
          ex[m][cyc+1].dg = dwin;
          ex[m][cyc+1].we = w;
          ex[m][cyc+1].ma = a;
          ex[m][cyc+1].mw = d;
          if (w) begin
            rmem[m][a[7:0]] = d;
            rwrote[m][a[7:0]] = 1'b1;
          end else begin
            if (dwin) ex[m][cyc+2].dv = 1'b1;
            else      ex[m][cyc+2].cv = 1'b1;
            ex[m][cyc+2].rd = rwrote[m][a[7:0]] ? rmem[m][a[7:0]] : init_val(a[7:0]);
          end
          last_dev[m] = dwin;
        end
        if (cur.dg)                      wcnt[m] = 0;
        else if (dev_req[m] && wcnt[m] < MW) wcnt[m]++;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int m = 0; m < 2; m++) begin
      cur = ex[m][cyc];
      chk($sformatf("ctl m%0d c%0d", m, cyc),
          {cpu_gnt[m], dev_gnt[m], cpu_rvalid[m], dev_rvalid[m], mem_we[m]},
          {cur.cg, cur.dg, cur.cv, cur.dv, cur.we});
      chk($sformatf("mem m%0d c%0d", m, cyc), {mem_addr[m], mem_wdata[m]}, {cur.ma, cur.mw});
      if (cur.cv) chk($sformatf("crd m%0d c%0d", m, cyc), cpu_rdata[m], cur.rd);
      if (cur.dv) chk($sformatf("drd m%0d c%0d", m, cyc), dev_rdata[m], cur.rd);
    end
  endtask

  initial begin
    bit [8:0] pc[2], pd[2];
    bit gnow, r;
    logic [AW-1:0] ra;
    for (int m = 0; m < 2; m++) begin
      setp(m, 0, 0, 0, '0, '0);
      setp(m, 1, 0, 0, '0, '0);
      wcnt[m] = 0;
      last_dev[m] = 1'b1;
      pc[m] = '0;
      pd[m] = '0;
    end
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // CPU write, then preload the directed read locations through the arbiter
    drive(0, 1, 1, 16'h00FF, 16'h1234);
    tick();
    chk("t2_wr", {mem_we[1], cpu_gnt[1], mem_addr[1], mem_wdata[1]}, {1'b1, 1'b1, 16'h00FF, 16'h1234});
    drive(0, 0, 0, '0, '0);
    tick();
    chk("t2_off", {mem_we[1], cpu_rvalid[1], cpu_gnt[1]}, 3'b000);
    tick();
    chk("t2_norv", {cpu_rvalid[1], cpu_rvalid[0]}, 2'b00);
    drive(0, 1, 1, 16'h0010, 16'hBEEF); tick(); drive(0, 0, 0, '0, '0); tick();
    drive(0, 1, 1, 16'h8000, 16'h00AA); tick(); drive(0, 0, 0, '0, '0); tick();
    drive(0, 1, 1, 16'h0002, 16'h5555); tick(); drive(0, 0, 0, '0, '0); tick();

    // CPU read
    drive(0, 1, 0, 16'h0010, '0);
    tick();
    chk("t1_gnt", {cpu_gnt[1], dev_gnt[1], mem_we[1], mem_addr[1]}, {1'b1, 1'b0, 1'b0, 16'h0010});
    drive(0, 0, 0, '0, '0);
    tick();
    chk("t1_rd", {cpu_rvalid[1], dev_rvalid[1], dev_gnt[1], cpu_rdata[1]}, {3'b100, 16'hBEEF});
    tick();

    // both requesters held high from cycle 0, both modes side by side
    reset = 1'b1; tick(); reset = 1'b0;
    drive(0, 1, 0, 16'h0020, '0);
    drive(1, 1, 0, 16'h0030, '0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        pc[m][i] = cpu_gnt[m];
        pd[m][i] = dev_gnt[m];
      end
    end
    chk("t3_cpu", pc[1], 9'b010001010);
    chk("t3_dev", pd[1], 9'b000100000);
    chk("t4_cpu", pc[0], 9'b000100010);
    chk("t4_dev", pd[0], 9'b010001000);
    drive(0, 0, 0, '0, '0); drive(1, 0, 0, '0, '0);
    tick(); tick();

    // reset during a device read's grant cycle
    drive(1, 1, 0, 16'h0040, '0);
    tick();
    chk("t5_gnt", dev_gnt[1], 1'b1);
    reset = 1'b1;
    drive(1, 0, 0, '0, '0);
    tick();
    chk("t5_zero", {cpu_gnt[1], dev_gnt[1], cpu_rvalid[1], dev_rvalid[1], mem_we[1], mem_addr[1], mem_wdata[1]}, '0);
    reset = 1'b0;
    tick();
    chk("t5_norv", {dev_rvalid[1], dev_rvalid[0]}, 2'b00);
    drive(0, 1, 0, 16'h0050, '0);
    tick();
    chk("t5_cpu", cpu_gnt[1], 1'b1);
    drive(0, 0, 0, '0, '0);
    tick(); tick();

    // device read then a CPU read arriving during the device grant
    drive(1, 1, 0, 16'h8000, '0);
    tick();
    drive(1, 0, 0, '0, '0);
    drive(0, 1, 0, 16'h0002, '0);
    tick();
    chk("t6_drd", {dev_rvalid[1], cpu_gnt[1], dev_rdata[1]}, {2'b10, 16'h00AA});
    tick();
    chk("t6_cgnt", {cpu_gnt[1], dev_gnt[1]}, 2'b10);
    drive(0, 0, 0, '0, '0);
    tick();
    chk("t6_crd", {cpu_rvalid[1], cpu_rdata[1]}, {1'b1, 16'h5555});
    tick();

    // random traffic with occasional resets
    for (int i = 0; i < 2500; i++) begin
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 299) == 0) reset = 1'b1;
      for (int m = 0; m < 2; m++) begin
        for (int p = 0; p < 2; p++) begin
          gnow = p ? ex[m][cyc].dg : ex[m][cyc].cg;
          r = p ? dev_req[m] : cpu_req[m];
          if (gnow || !r) begin
            ra = {8'($urandom), 4'h0, 4'($urandom)};
            setp(m, p[0], $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, ra, 16'($urandom));
          end
        end
      end
      tick();
    end
    reset = 1'b0;
    drive(0, 0, 0, '0, '0); drive(1, 0, 0, '0, '0);
    tick(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
